// File: rtl/spmv_pkg.sv
// Shared definitions for the SpMV feeder / accumulation core pair:
// word widths, batch size, feeder FSM encoding and core phase codes.
package spmv_pkg;

  localparam int unsigned DATA_W = 16;  // fp16 values and vector elements
  localparam int unsigned ADDR_W = 8;   // RAM address and element-count width
  localparam int unsigned BATCH  = 16;  // elements per core run
  localparam int unsigned PH_W   = 2;   // core phase counter width

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PF_ADDR  = 3'd1,
    ST_PF_X     = 3'd2,
    ST_PF_LATCH = 3'd3,
    ST_START    = 3'd4,
    ST_RUN      = 3'd5,
    ST_RESTART  = 3'd6,
    ST_DONE     = 3'd7
  } state_e;

  // Phase codes mirror the core's LOAD/MUL/ADD/WRITE rhythm.
  localparam logic [PH_W-1:0] PH_LOAD  = 2'd0;
  localparam logic [PH_W-1:0] PH_MUL   = 2'd1;
  localparam logic [PH_W-1:0] PH_ADD   = 2'd2;
  localparam logic [PH_W-1:0] PH_WRITE = 2'd3;

endpackage

// File: rtl/spmv_prefetch_stage.sv
// Two-step col->x fetch and staging for the SpMV feeder.
// Ports:
//   i_clk, i_rstn      clock, async active-low reset
//   i_val_lat_en       value/col data valid: stage value, forward col as x address
//   i_x_lat_en         x data valid: stage vector element
//   i_load_en          copy staged pair into the core-facing data registers
//   i_val_data/i_col_data/i_x_data   RAM read data
//   o_x_addr           dense-vector RAM address
//   o_data_a/o_data_b  matrix value / vector value presented to the core
module spmv_prefetch_stage
  import spmv_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_val_lat_en,
  input  logic              i_x_lat_en,
  input  logic              i_load_en,
  input  logic [DATA_W-1:0] i_val_data,
  input  logic [ADDR_W-1:0] i_col_data,
  input  logic [DATA_W-1:0] i_x_data,
  output logic [ADDR_W-1:0] o_x_addr,
  output logic [DATA_W-1:0] o_data_a,
  output logic [DATA_W-1:0] o_data_b
);

  logic [DATA_W-1:0] stage_a_q, stage_a_d;
  logic [DATA_W-1:0] stage_b_q, stage_b_d;
  logic [ADDR_W-1:0] x_addr_q,  x_addr_d;
  logic [DATA_W-1:0] data_a_q,  data_a_d;
  logic [DATA_W-1:0] data_b_q,  data_b_d;

  // Staging and output updates; a load in the same cycle as the x latch
  // takes the incoming x word so the pair is complete at the cycle end.
  always_comb begin
    stage_a_d = stage_a_q;
    stage_b_d = stage_b_q;
    x_addr_d  = x_addr_q;
    data_a_d  = data_a_q;
    data_b_d  = data_b_q;
    if (i_val_lat_en) begin
      stage_a_d = i_val_data;
      x_addr_d  = i_col_data;
    end
    if (i_x_lat_en) begin
      stage_b_d = i_x_data;
    end
    if (i_load_en) begin
      data_a_d = stage_a_q;
      data_b_d = stage_b_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      stage_a_q <= '0;
      stage_b_q <= '0;
      x_addr_q  <= '0;
      data_a_q  <= '0;
      data_b_q  <= '0;
    end else begin
      stage_a_q <= stage_a_d;
      stage_b_q <= stage_b_d;
      x_addr_q  <= x_addr_d;
      data_a_q  <= data_a_d;
      data_b_q  <= data_b_d;
    end
  end

  // The column index arrives in the same cycle the x address must be
  // presented, so it is forwarded straight through and held afterwards.
  assign o_x_addr = i_val_lat_en ? i_col_data : x_addr_q;
  assign o_data_a = data_a_q;
  assign o_data_b = data_b_q;

endmodule

// File: rtl/spmv_csr_feeder.sv
// Sequencer that streams CSR nonzeros and matching vector elements into the
// SpMV accumulation core in lock-step with its 4-cycle rhythm, relaunching
// the core per batch until all nonzeros are consumed.
// Ports:
//   i_clk, i_rstn                 clock, async active-low reset
//   i_start, i_nnz                start pulse (IDLE only), total nonzeros
//   o_val_addr/o_col_addr         value / column RAM address (always equal)
//   i_val_data/i_col_data         value / column RAM data (1-cycle latency)
//   o_x_addr, i_x_data            dense-vector RAM address / data
//   o_core_start                  one-cycle core launch
//   o_read_data_A/B, o_count      operands and element count to the core
//   i_core_done                   core finished its run
//   o_busy, o_done                run in progress / completion pulse
module spmv_csr_feeder
  import spmv_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_nnz,
  output logic [ADDR_W-1:0] o_val_addr,
  input  logic [DATA_W-1:0] i_val_data,
  output logic [ADDR_W-1:0] o_col_addr,
  input  logic [ADDR_W-1:0] i_col_data,
  output logic [ADDR_W-1:0] o_x_addr,
  input  logic [DATA_W-1:0] i_x_data,
  output logic              o_core_start,
  output logic [DATA_W-1:0] o_read_data_A,
  output logic [DATA_W-1:0] o_read_data_B,
  output logic [ADDR_W-1:0] o_count,
  input  logic              i_core_done,
  output logic              o_busy,
  output logic              o_done
);

  state_e            state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [ADDR_W-1:0] nnz_q, nnz_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [ADDR_W-1:0] val_addr_q, val_addr_d;
  logic              core_start_q, core_start_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W:0]   next_idx;
  logic              val_lat_en, x_lat_en, load_en;

  // State register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q      <= ST_IDLE;
      phase_q      <= PH_LOAD;
      nnz_q        <= '0;
      count_q      <= '0;
      val_addr_q   <= '0;
      core_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      nnz_q        <= nnz_d;
      count_q      <= count_d;
      val_addr_q   <= val_addr_d;
      core_start_q <= core_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Next state; in WRITE the core's done flag decides, count picks the target
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_start) state_d = (i_nnz == '0) ? ST_DONE : ST_PF_ADDR;
      end
      ST_PF_ADDR:  state_d = ST_PF_X;
      ST_PF_X:     state_d = ST_PF_LATCH;
      ST_PF_LATCH: state_d = ST_START;
      ST_START: begin
        state_d = ST_RUN;
        phase_d = PH_LOAD;
      end
      ST_RUN: begin
        phase_d = PH_W'(phase_q + PH_W'(1));
        if (phase_q == PH_WRITE && i_core_done) begin
          state_d = (count_q == nnz_q) ? ST_DONE : ST_RESTART;
        end
      end
      ST_RESTART: begin
        state_d = ST_RUN;
        phase_d = PH_LOAD;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs and datapath controls
  always_comb begin
    nnz_d        = nnz_q;
    count_d      = count_q;
    val_addr_d   = val_addr_q;
    val_lat_en   = 1'b0;
    x_lat_en     = 1'b0;
    load_en      = 1'b0;
    next_idx     = {1'b0, count_q} + (ADDR_W + 1)'(1);
    core_start_d = (state_d == ST_START) || (state_d == ST_RESTART);
    busy_d       = (state_d != ST_IDLE);
    done_d       = (state_d == ST_DONE);

    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          nnz_d   = i_nnz;
          count_d = '0;
          if (i_nnz != '0) val_addr_d = '0;
        end
      end
      ST_PF_X: val_lat_en = 1'b1;
      ST_PF_LATCH: begin
        x_lat_en = 1'b1;
        load_en  = 1'b1;
      end
      ST_RUN: begin
        unique case (phase_q)
          PH_MUL: val_lat_en = 1'b1;
          PH_ADD: begin
            x_lat_en = 1'b1;
            count_d  = ADDR_W'(count_q + ADDR_W'(1));
          end
          PH_WRITE: load_en = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase

    // Address for the next element is presented throughout LOAD
    if (state_d == ST_RUN && phase_d == PH_LOAD && next_idx < {1'b0, nnz_q}) begin
      val_addr_d = next_idx[ADDR_W-1:0];
    end
  end

  spmv_prefetch_stage u_prefetch (
    .i_clk        (i_clk),
    .i_rstn       (i_rstn),
    .i_val_lat_en (val_lat_en),
    .i_x_lat_en   (x_lat_en),
    .i_load_en    (load_en),
    .i_val_data   (i_val_data),
    .i_col_data   (i_col_data),
    .i_x_data     (i_x_data),
    .o_x_addr     (o_x_addr),
    .o_data_a     (o_read_data_A),
    .o_data_b     (o_read_data_B)
  );

  assign o_val_addr   = val_addr_q;
  assign o_col_addr   = val_addr_q;
  assign o_core_start = core_start_q;
  assign o_count      = count_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;

endmodule

// File: tb/tb_spmv_csr_feeder.sv
// Directed bench for spmv_csr_feeder with synchronous-read RAM models and a
// behavioural 4-phase core. Cycle 0 is the cycle in which i_start is high.
module tb_spmv_csr_feeder;
  import spmv_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_start = 1'b0;
  logic [ADDR_W-1:0] i_nnz = '0;
  logic [ADDR_W-1:0] o_val_addr, o_col_addr, o_x_addr, o_count;
  logic [DATA_W-1:0] i_val_data, i_x_data, o_read_data_A, o_read_data_B;
  logic [ADDR_W-1:0] i_col_data;
  logic              o_core_start, i_core_done, o_busy, o_done;

  logic [DATA_W-1:0] val_mem [256];
  logic [ADDR_W-1:0] col_mem [256];
  logic [DATA_W-1:0] x_mem   [256];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int c0    = 0;
  int cur_nnz = 0;
  int core_ph = -1;   // -1 idle, 0..3 LOAD/MUL/ADD/WRITE
  int addr_act = 0;

  int cs_q[$];
  int done_q[$];
  int ld_cyc[$];
  int ld_a[$];
  int ld_b[$];
  int ld_cnt[$];
  int wr_cnt[$];

  spmv_csr_feeder dut (
    .i_clk         (clk),
    .i_rstn        (rst_n),
    .i_start       (i_start),
    .i_nnz         (i_nnz),
    .o_val_addr    (o_val_addr),
    .i_val_data    (i_val_data),
    .o_col_addr    (o_col_addr),
    .i_col_data    (i_col_data),
    .o_x_addr      (o_x_addr),
    .i_x_data      (i_x_data),
    .o_core_start  (o_core_start),
    .o_read_data_A (o_read_data_A),
    .o_read_data_B (o_read_data_B),
    .o_count       (o_count),
    .i_core_done   (i_core_done),
    .o_busy        (o_busy),
    .o_done        (o_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read RAMs
  always @(posedge clk) begin
    i_val_data <= val_mem[o_val_addr];
    i_col_data <= col_mem[o_col_addr];
    i_x_data   <= x_mem[o_x_addr];
  end

  // Core model: finishes on a nonzero multiple of BATCH or on the last element
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) core_ph <= -1;
    else if (core_ph == -1) begin
      if (o_core_start) core_ph <= 0;
    end else if (core_ph == 3) core_ph <= i_core_done ? -1 : 0;
    else core_ph <= core_ph + 1;
  end
  assign i_core_done = (core_ph == 3) && (o_count != 0) &&
                       ((int'(o_count) % BATCH == 0) || (int'(o_count) == cur_nnz));

  // Event log sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_core_start) cs_q.push_back(cyc);
      if (o_done) done_q.push_back(cyc);
      if (core_ph == 0) begin
        ld_cyc.push_back(cyc);
        ld_a.push_back(int'(o_read_data_A));
        ld_b.push_back(int'(o_read_data_B));
        ld_cnt.push_back(int'(o_count));
      end
      if (core_ph == 3) wr_cnt.push_back(int'(o_count));
      if (o_val_addr != '0 || o_x_addr != '0) addr_act++;
    end
  end

  function automatic int exp_load(input int k);
    return 5 + 4 * k + k / BATCH;
  endfunction

  task automatic do_start(input int n);
    cs_q.delete(); done_q.delete(); ld_cyc.delete(); ld_a.delete();
    ld_b.delete(); ld_cnt.delete(); wr_cnt.delete();
    addr_act = 0;
    cur_nnz = n;
    @(posedge clk); #1;
    i_nnz = ADDR_W'(n);
    i_start = 1'b1;
    c0 = cyc;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    for (int i = 0; i < max_cyc && done_q.size() == 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    total++;
    if ({o_val_addr, o_col_addr, o_x_addr, o_count, o_read_data_A, o_read_data_B,
         o_core_start, o_busy, o_done} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got A=%h B=%h cnt=%0d busy=%b done=%b, expected all 0",
               o_read_data_A, o_read_data_B, o_count, o_busy, o_done);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_zero_nnz;
    int got_done;
    do_start(0);
    wait_done(20);
    got_done = (done_q.size() > 0) ? done_q[0] - c0 : -1;
    total++;
    if (got_done !== 1 || done_q.size() != 1) begin
      bad++;
      $display("FAIL zero_done: got cycle %0d (n=%0d), expected cycle 1 once", got_done, done_q.size());
    end
    total++;
    if (cs_q.size() != 0) begin
      bad++;
      $display("FAIL zero_core_start: got %0d starts, expected 0", cs_q.size());
    end
    total++;
    if (addr_act != 0) begin
      bad++;
      $display("FAIL zero_addr: got %0d active-address cycles, expected 0", addr_act);
    end
  endtask

  task automatic test_single_element;
    do_start(1);
    for (int n = 1; n <= 11; n++) begin
      @(negedge clk);
      total++;
      if (o_core_start !== (n == 4)) begin
        bad++;
        $display("FAIL single_core_start c%0d: got %b, expected %b", n, o_core_start, n == 4);
      end
      total++;
      if (o_done !== (n == 9)) begin
        bad++;
        $display("FAIL single_done c%0d: got %b, expected %b", n, o_done, n == 9);
      end
      if (n == 5) begin
        total++;
        if (o_read_data_A !== 16'h3C00 || o_read_data_B !== 16'h4000 || o_count !== 8'd0) begin
          bad++;
          $display("FAIL single_load: got A=%h B=%h cnt=%0d, expected A=3c00 B=4000 cnt=0",
                   o_read_data_A, o_read_data_B, o_count);
        end
        total++;
        if (o_busy !== 1'b1) begin
          bad++;
          $display("FAIL single_busy: got %b, expected 1", o_busy);
        end
      end
      if (n == 8) begin
        total++;
        if (o_count !== 8'd1) begin
          bad++;
          $display("FAIL single_count_write: got %0d, expected 1", o_count);
        end
      end
      if (n == 11) begin
        total++;
        if (o_busy !== 1'b0 || o_count !== 8'd1) begin
          bad++;
          $display("FAIL single_after: got busy=%b cnt=%0d, expected busy=0 cnt=1", o_busy, o_count);
        end
      end
    end
  endtask

  task automatic test_batches;
    int sizes[3] = '{5, 16, 20};
    for (int s = 0; s < 3; s++) begin
      int n, nb, got_done, exp_cs, exp_done;
      n = sizes[s];
      nb = (n + BATCH - 1) / BATCH;
      exp_done = exp_load(n - 1) + 4;
      do_start(n);
      wait_done(300);
      got_done = (done_q.size() > 0) ? done_q[0] - c0 : -1;
      total++;
      if (got_done != exp_done || done_q.size() != 1) begin
        bad++;
        $display("FAIL batch%0d_done: got cycle %0d, expected %0d", n, got_done, exp_done);
      end
      total++;
      if (cs_q.size() != nb) begin
        bad++;
        $display("FAIL batch%0d_starts: got %0d core starts, expected %0d", n, cs_q.size(), nb);
      end
      for (int b = 0; b < nb && b < cs_q.size(); b++) begin
        exp_cs = (b == 0) ? 4 : exp_load(b * BATCH) - 1;
        total++;
        if (cs_q[b] - c0 != exp_cs) begin
          bad++;
          $display("FAIL batch%0d_start%0d: got cycle %0d, expected %0d", n, b, cs_q[b] - c0, exp_cs);
        end
      end
      total++;
      if (ld_cyc.size() != n || wr_cnt.size() != n) begin
        bad++;
        $display("FAIL batch%0d_loads: got %0d loads %0d writes, expected %0d", n, ld_cyc.size(), wr_cnt.size(), n);
      end
      for (int k = 0; k < n && k < ld_cyc.size() && k < wr_cnt.size(); k++) begin
        total++;
        if (ld_cyc[k] - c0 != exp_load(k) || ld_a[k] != int'(val_mem[k]) ||
            ld_b[k] != int'(x_mem[col_mem[k]]) || ld_cnt[k] != k || wr_cnt[k] != k + 1) begin
          bad++;
          $display("FAIL batch%0d_elem%0d: got c%0d A=%h B=%h cnt=%0d wcnt=%0d, expected c%0d A=%h B=%h cnt=%0d wcnt=%0d",
                   n, k, ld_cyc[k] - c0, ld_a[k], ld_b[k], ld_cnt[k], wr_cnt[k],
                   exp_load(k), val_mem[k], x_mem[col_mem[k]], k, k + 1);
        end
      end
      total++;
      if (int'(o_count) != n || o_busy !== 1'b0) begin
        bad++;
        $display("FAIL batch%0d_final: got cnt=%0d busy=%b, expected cnt=%0d busy=0", n, o_count, o_busy, n);
      end
    end
  endtask

  task automatic test_reset_midrun;
    int got_done;
    do_start(20);
    for (int i = 0; i < 100 && cyc < c0 + 30; i++) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({o_val_addr, o_x_addr, o_count, o_read_data_A, o_read_data_B,
         o_core_start, o_busy, o_done} !== '0) begin
      bad++;
      $display("FAIL midrun_reset: got cnt=%0d A=%h B=%h busy=%b, expected all 0",
               o_count, o_read_data_A, o_read_data_B, o_busy);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    do_start(20);
    wait_done(300);
    got_done = (done_q.size() > 0) ? done_q[0] - c0 : -1;
    total++;
    if (got_done != 86) begin
      bad++;
      $display("FAIL replay_done: got cycle %0d, expected 86", got_done);
    end
    total++;
    if (ld_cyc.size() != 20) begin
      bad++;
      $display("FAIL replay_loads: got %0d, expected 20", ld_cyc.size());
    end
    for (int k = 0; k < 20 && k < ld_cyc.size(); k++) begin
      total++;
      if (ld_cyc[k] - c0 != exp_load(k) || ld_a[k] != int'(val_mem[k]) || ld_cnt[k] != k) begin
        bad++;
        $display("FAIL replay_elem%0d: got c%0d A=%h cnt=%0d, expected c%0d A=%h cnt=%0d",
                 k, ld_cyc[k] - c0, ld_a[k], ld_cnt[k], exp_load(k), val_mem[k], k);
      end
    end
  endtask

  initial begin
    for (int j = 0; j < 256; j++) begin
      val_mem[j] = 16'h3C00 + 16'(j);
      col_mem[j] = 8'((j * 7 + 3) % 61);
      x_mem[j]   = 16'h4000 + 16'((j ^ 3) * 16);
    end
    test_reset;
    test_zero_nnz;
    test_single_element;
    test_batches;
    test_reset_midrun;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
